// File: rtl/wb_pkg.sv
// Shared Wishbone interconnect types: arbitration policy and arbiter FSM states.
package wb_pkg;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } arb_mode_t;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_t;

    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

endpackage

// File: rtl/if_wb.sv
// Wishbone pipelined bus bundle; master drives the request, slave returns ack/stall/data.
interface if_wb #(
    parameter int AWIDTH = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [AWIDTH-1:0] adr;
    logic [3:0]        sel;
    logic [31:0]       dat_m;
    logic [31:0]       dat_s;
    logic              ack;
    logic              stall;

    modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, stall);
    modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/rr_pick.sv
// Combinational arbiter pick: rotating priority after the last grant, or fixed lowest-index.
module rr_pick
    import wb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    input  arb_mode_t     mode_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic found;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        found   = 1'b0;
        if (mode_i == ARB_FIXED) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) idx_o = IW'(i);
            end
        end else begin
            // Scan starts one past the last winner so the previous owner ranks lowest.
            for (int k = 1; k <= N; k++) begin
                if (!found && req_i[(int'(last_i) + k) % N]) begin
                    idx_o = IW'((int'(last_i) + k) % N);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// N-to-1 Wishbone pipelined arbiter: one master owns the slave per bus cycle,
// with a cap on outstanding un-acked requests.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int        NMASTERS = 2,
    parameter int        AWIDTH   = 32,
    parameter int        MAXOUT   = 4,
    parameter arb_mode_t MODE     = ARB_RR
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NMASTERS-1:0]                m_cyc,
    input  logic [NMASTERS-1:0]                m_stb,
    input  logic [NMASTERS-1:0]                m_we,
    input  logic [NMASTERS-1:0][AWIDTH-1:0]    m_adr,
    input  logic [NMASTERS-1:0][WB_SW-1:0]     m_sel,
    input  logic [NMASTERS-1:0][WB_DW-1:0]     m_dat_m,
    output logic [NMASTERS-1:0]                m_ack,
    output logic [NMASTERS-1:0]                m_stall,
    output logic [WB_DW-1:0]                   m_dat_s,
    if_wb.master                               s_bus
);

    localparam int IW = $clog2(NMASTERS);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] last_q, last_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic          full;
    logic          bus_cyc, bus_stb;
    logic          accept, ack_cnt;

    rr_pick #(.N(NMASTERS)) u_pick (
        .req_i   (m_cyc),
        .last_i  (last_q),
        .mode_i  (MODE),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign full    = (cnt_q == 4'(MAXOUT));
    assign accept  = bus_stb & ~s_bus.stall;
    // An ack with nothing outstanding is still forwarded but must not underflow the count.
    assign ack_cnt = s_bus.ack & (cnt_q != 4'd0);

    assign s_bus.cyc   = bus_cyc;
    assign s_bus.stb   = bus_stb;
    assign s_bus.adr   = m_adr[g_q];
    assign s_bus.we    = m_we[g_q];
    assign s_bus.sel   = m_sel[g_q];
    assign s_bus.dat_m = m_dat_m[g_q];
    assign m_dat_s     = s_bus.dat_s;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        bus_cyc = 1'b0;
        bus_stb = 1'b0;
        m_stall = '1;
        m_ack   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    g_d     = pick_idx;
                    last_d  = pick_idx;
                end
            end
            OWN: begin
                bus_cyc     = m_cyc[g_q];
                bus_stb     = m_stb[g_q] & ~full;
                m_stall[g_q] = s_bus.stall | full;
                m_ack[g_q]   = s_bus.ack;
                if (accept && !ack_cnt)      cnt_d = cnt_q + 4'd1;
                else if (!accept && ack_cnt) cnt_d = cnt_q - 4'd1;
                // Release drops any still-pending acks: the count restarts for the next owner.
                if (!m_cyc[g_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(NMASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
